// File: rtl/parity_frame_checker.sv
// Serial receive checker: LSB-first byte plus parity bit, with AND/OR reduction flags
// and a single-entry valid/ready output slot. Define PFC_STATS_EN to add err_count.
module parity_frame_checker #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       bit_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_par_err,
  output logic       out_all_ones,
  output logic       out_any_one,
  output logic       overrun,
  output logic       frame_err
`ifdef PFC_STATS_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] shreg;

  logic frame_done;
  logic par_err_now;
  logic slot_load;

  function automatic logic calc_par_err(input logic [7:0] d, input logic p);
    calc_par_err = (^d) ^ p ^ ODD_PARITY;
  endfunction

  assign frame_done  = bit_valid && !bit_sof && (state == PARITY);
  assign par_err_now = calc_par_err(shreg, bit_in);
  // A completing frame may reuse the slot in the same cycle the consumer drains it.
  assign slot_load   = frame_done && (!out_valid || out_ready);

  // ---- bit assembly FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shreg     <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bit_valid) begin
        if (bit_sof) begin
          // SOF always starts a new frame; outside IDLE it also aborts the current one.
          shreg     <= {7'd0, bit_in};
          cnt       <= 3'd1;
          state     <= DATA;
          frame_err <= (state != IDLE);
        end else begin
          case (state)
            DATA: begin
              shreg[cnt] <= bit_in;
              cnt        <= cnt + 3'd1;
              if (cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              state <= IDLE;
              cnt   <= 3'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---- output slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= 8'd0;
      out_par_err  <= 1'b0;
      out_all_ones <= 1'b0;
      out_any_one  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= frame_done && !slot_load;
      if (slot_load) begin
        out_valid    <= 1'b1;
        out_data     <= shreg;
        out_par_err  <= par_err_now;
        out_all_ones <= &shreg;
        out_any_one  <= |shreg;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PFC_STATS_EN
  // Counts every parity failure, including frames dropped on overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (frame_done && par_err_now && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: even-parity and odd-parity instances
// driven by directed frames, with a decoupled monitor popping expected slots.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_sof = 1'b0;
  logic valid_e = 1'b0;
  logic valid_o = 1'b0;
  logic ready_e = 1'b1;
  logic ready_o = 1'b1;
  logic sel = 1'b0;

  logic       ov_e, ov_o;
  logic [7:0] od_e, od_o;
  logic       pe_e, pe_o, ao_e, ao_o, a1_e, a1_o;
  logic       orun_e, orun_o, ferr_e, ferr_o;
`ifdef PFC_STATS_EN
  logic [7:0] ec_e, ec_o;
`endif

  always #5 clk = ~clk;

  parity_frame_checker #(.ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .bit_valid(valid_e), .bit_in(bit_in), .bit_sof(bit_sof),
    .out_valid(ov_e), .out_ready(ready_e), .out_data(od_e), .out_par_err(pe_e),
    .out_all_ones(ao_e), .out_any_one(a1_e), .overrun(orun_e), .frame_err(ferr_e)
`ifdef PFC_STATS_EN
    , .err_count(ec_e)
`endif
  );

  parity_frame_checker #(.ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .bit_valid(valid_o), .bit_in(bit_in), .bit_sof(bit_sof),
    .out_valid(ov_o), .out_ready(ready_o), .out_data(od_o), .out_par_err(pe_o),
    .out_all_ones(ao_o), .out_any_one(a1_o), .overrun(orun_o), .frame_err(ferr_o)
`ifdef PFC_STATS_EN
    , .err_count(ec_o)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       ao;
    logic       a1;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  int checks = 0;
  int errors = 0;
  int n_orun_e = 0, n_ferr_e = 0, n_orun_o = 0, n_ferr_o = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every handshaken slot against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (orun_e) n_orun_e++;
      if (ferr_e) n_ferr_e++;
      if (orun_o) n_orun_o++;
      if (ferr_o) n_ferr_o++;
      if (ov_e && ready_e) begin
        if (q_e.size() == 0) chk("even_unexpected_slot", {24'd0, od_e}, 32'hFFFF_FFFF);
        else begin
          exp_t x;
          x = q_e.pop_front();
          chk("even_slot", {20'd0, od_e, pe_e, ao_e, a1_e}, {20'd0, x.d, x.pe, x.ao, x.a1});
        end
      end
      if (ov_o && ready_o) begin
        if (q_o.size() == 0) chk("odd_unexpected_slot", {24'd0, od_o}, 32'hFFFF_FFFF);
        else begin
          exp_t y;
          y = q_o.pop_front();
          chk("odd_slot", {20'd0, od_o, pe_o, ao_o, a1_o}, {20'd0, y.d, y.pe, y.ao, y.a1});
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    @(posedge clk); #1;
    bit_in  = b;
    bit_sof = s;
    valid_e = !sel;
    valid_o = sel;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_e = 1'b0;
      valid_o = 1'b0;
      bit_sof = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_bit(d[0], 1'b1);
    for (int i = 1; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(p, 1'b0);
  endtask

  task automatic push_e(input logic [7:0] d, input logic pe, input logic ao, input logic a1);
    exp_t x;
    x.d = d; x.pe = pe; x.ao = ao; x.a1 = a1;
    q_e.push_back(x);
  endtask

  task automatic push_o(input logic [7:0] d, input logic pe, input logic ao, input logic a1);
    exp_t x;
    x.d = d; x.pe = pe; x.ao = ao; x.a1 = a1;
    q_o.push_back(x);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_out_valid"}, {31'd0, ov_e}, 32'd0);
    chk({name, "_out_data"}, {24'd0, od_e}, 32'd0);
    chk({name, "_flags"}, {28'd0, pe_e, ao_e, a1_e, orun_e}, 32'd0);
    chk({name, "_frame_err"}, {31'd0, ferr_e}, 32'd0);
  endtask

  initial begin
    int budget;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
`ifdef PFC_STATS_EN
    chk("reset_err_count", {24'd0, ec_e}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // 0xA5, even parity: slot appears the cycle after the parity bit
    push_e(8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0);
    idle(1);
    @(negedge clk);
    chk("a5_latency_out_valid", {31'd0, ov_e}, 32'd1);
    idle(3);

    // 0xFF then 0x00 back-to-back
    push_e(8'hFF, 1'b0, 1'b1, 1'b1);
    push_e(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'h00, 1'b1);
    idle(3);
`ifdef PFC_STATS_EN
    @(negedge clk);
    chk("err_count_after_b2b", {24'd0, ec_e}, 32'd1);
`endif

    // overrun: slot holds 0x11, 0x22 dropped
    ready_e = 1'b0;
    push_e(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    idle(4);
    @(negedge clk);
    chk("overrun_hold_data", {24'd0, od_e}, 32'h11);
    chk("overrun_pulses", n_orun_e, 32'd1);
    @(posedge clk); #1;
    ready_e = 1'b1;
    idle(1);
    @(negedge clk);
    chk("drain_one_cycle", {31'd0, ov_e}, 32'd0);

    // early SOF on the 5th bit restarts the frame as 0x3C
    push_e(8'h3C, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(8'h3C, 1'b0);
    idle(3);
    chk("frame_err_pulses", n_ferr_e, 32'd1);

    // reset mid-frame, including a bit presented while reset is high
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bit_in = 1'b1; bit_sof = 1'b1; valid_e = 1'b1;
    @(posedge clk); #1;
    valid_e = 1'b0; bit_sof = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");
`ifdef PFC_STATS_EN
    chk("post_rst_err_count", {24'd0, ec_e}, 32'd0);
`endif
    push_e(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0);
    idle(3);

    // parity errors involving the edge bit positions
    push_e(8'h01, 1'b1, 1'b0, 1'b1);
    push_e(8'h80, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0);
    send_frame(8'h80, 1'b1);
    idle(3);
`ifdef PFC_STATS_EN
    @(negedge clk);
    chk("err_count_final", {24'd0, ec_e}, 32'd1);
`endif

    // odd-parity instance
    sel = 1'b1;
    push_o(8'h00, 1'b0, 1'b0, 1'b0);
    push_o(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b0);
    idle(3);

    budget = 0;
    while ((q_e.size() != 0 || q_o.size() != 0) && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    chk("even_queue_drained", q_e.size(), 32'd0);
    chk("odd_queue_drained", q_o.size(), 32'd0);
    chk("total_overrun_even", n_orun_e, 32'd1);
    chk("total_frame_err_even", n_ferr_e, 32'd1);
    chk("odd_status_pulses", n_orun_o + n_ferr_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial-in receive checker for parity-protected byte frames. It shifts in 8 data bits LSB-first plus one parity bit, validates the parity, and computes AND/OR reduction flags over the received byte. Each completed frame is presented on a registered valid/ready output slot. It is the receive-side counterpart of the byte reduction/parity generation logic, sitting between a serial link and downstream byte consumers.

## Interface
- `ODD_PARITY`, default 0: 0 = even parity (XOR of 8 data bits and the parity bit is 0); 1 = odd parity (that XOR is 1).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous, active-high.
- `bit_valid`  input  1  `bit_in` is valid this cycle; no backpressure.
- `bit_in`  input  1  serial data/parity bit.
- `bit_sof`  input  1  qualified by `bit_valid`; marks data bit 0 of a new frame.
- `out_valid`  output  1  output slot holds a frame.
- `out_ready`  input  1  consumer accepts the slot this cycle.
- `out_data`  output  8  received byte; bit k is the k-th data bit received.
- `out_par_err`  output  1  parity check failed for `out_data`.
- `out_all_ones`  output  1  `&out_data`.
- `out_any_one`  output  1  `|out_data`.
- `overrun`  output  1  one-cycle pulse: a completed frame was dropped.
- `frame_err`  output  1  one-cycle pulse: a frame was aborted by an early `bit_sof`.
- `err_count`  output  8  present only with `PFC_STATS_EN`; see Configuration.

## Operation
- FSM states: IDLE, DATA, PARITY. A 3-bit bit counter is used in DATA. An 8-bit shift register loads at bit position `cnt`.
- IDLE: `bit_valid && bit_sof` stores `bit_in` as bit 0, sets cnt=1, and moves to DATA. `bit_valid && !bit_sof` is ignored.
- DATA: on `bit_valid && !bit_sof`, store the bit at position cnt and increment cnt. After bit 7 is stored, move to PARITY.
- PARITY: on `bit_valid && !bit_sof`, the frame completes.
  - par_err = `^data ^ bit_in ^ ODD_PARITY`.
  - Flags are computed from the 8 data bits.
  - The FSM returns to IDLE.
- Early SOF: `bit_valid && bit_sof` in DATA or PARITY aborts the current frame with no output. `frame_err` pulses, and the bit is taken as bit 0 of a new frame (cnt=1, state DATA).
- Output slot, when a frame completes:
  - If the slot is empty, or `out_valid && out_ready` in the same cycle, the slot loads the frame and `out_valid`=1.
  - Otherwise the frame is dropped, `overrun` pulses, and the slot is unchanged.
- `out_valid && out_ready` with no completing frame clears `out_valid`.
- Slot contents (`out_data`/flags) hold stable while `out_valid && !out_ready`.
- Reset values: state IDLE, cnt 0, shift register 0, and all outputs 0 (`out_valid`, `out_data`, `out_par_err`, `out_all_ones`, `out_any_one`, `overrun`, `frame_err`, `err_count`).
- Reset asserted mid-frame discards the partial frame and any held slot. Bits presented during reset are ignored.

## Timing
- Parity bit accepted at cycle N: `out_valid` and the slot fields are valid at cycle N+1. `overrun` pulses at cycle N+1 instead if the frame is dropped.
- Early-SOF bit at cycle N: `frame_err` is high at cycle N+1 only.
- Minimum frame length is 9 accepted bits. Back-to-back frames at one bit per cycle are supported with no idle cycles.
- Throughput is 1 frame per 9 cycles. The slot drains in 1 cycle when `out_ready` is high.
- `out_valid` deasserts at cycle N+1 after a handshake at cycle N unless reloaded in that same cycle.

## Configuration
- `PFC_STATS_EN` defined:
  - `err_count` port exists. It is an 8-bit counter that increments on every completed frame with par_err=1, whether delivered or dropped.
  - It saturates at 255 and resets to 0.
- Not defined: the `err_count` port and its counter are absent. All other behaviour is identical.

## Test plan
- Frame 0xA5, even parity (bits 1,0,1,0,0,1,0,1 then 0) -> next cycle `out_valid`=1, `out_data`=0xA5, `out_par_err`=0, `out_all_ones`=0, `out_any_one`=1.
- 0xFF with parity 0, then 0x00 with parity 1, back-to-back, `out_ready`=1 -> first slot 0xFF, err 0, all_ones 1. Second slot 0x00, err 1, any_one 0. With `PFC_STATS_EN`, `err_count`=1.
- `ODD_PARITY`=1, 0x00 with parity 1 -> `out_par_err`=0. Same byte with parity 0 -> `out_par_err`=1.
- `out_ready`=0, two complete frames 0x11 then 0x22 -> slot holds 0x11, `overrun` pulses once after the second parity bit. Then `out_ready`=1 drains 0x11 in one cycle.
- `bit_sof` asserted on the 5th bit of a frame, followed by 8 bits + parity encoding 0x3C -> `frame_err` pulses once and the only output is 0x3C.
- `rst` pulsed after 4 data bits, then a full 0x5A frame -> only 0x5A is output, with all status outputs 0 before it.
